csa_operand_sequencer: RTL and testbench

- Stream front-end/back-end wrapped around the 3-input 4-bit carry-save adder stage.
- Accepts a serial valid/ready stream of 4-bit operands and packs them into triples.
- Drives the triple onto the external CSA x/y/z inputs, captures the CSA result {cout,s} as a 6-bit sum, and presents it downstream with valid/ready.
- Also self-checks the CSA against a behavioural x+y+z and flags mismatches.

---
 rtl/csa_operand_sequencer_if.sv | 27 ++
 rtl/csa_operand_sequencer.sv | 173 +++++++++++++++++
 tb/tb_csa_operand_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/csa_operand_sequencer_if.sv
// Stream interface of the CSA operand sequencer: operand input stream and
// result output stream, each with its own valid/ready handshake.
interface csa_operand_sequencer_if #(
    parameter int OP_W = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [OP_W+1:0] out_sum;
    logic [1:0]      out_nops;
    logic            out_last;

    // Sequencer side: consumes operands, produces results.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_nops, out_last
    );

    // Environment side: produces operands, consumes results.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_nops, out_last
    );
endinterface

// File: rtl/csa_operand_sequencer.sv
// Packs a serial stream of 4-bit operands into triples, drives them into an
// external 3-input carry-save adder stage, captures its 6-bit result and
// hands it downstream. The CSA result is cross-checked against a plain
// x+y+z and any disagreement raises a sticky error flag.
module csa_operand_sequencer #(
    parameter int OP_W  = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    csa_operand_sequencer_if.slave bus,
    output logic [OP_W-1:0]        csa_x,
    output logic [OP_W-1:0]        csa_y,
    output logic [OP_W-1:0]        csa_z,
    input  logic [OP_W:0]          csa_s,
    input  logic                   csa_cout,
    output logic [CNT_W-1:0]       grp_cnt,
    output logic                   err
);

    typedef enum logic [2:0] {
        LOAD0 = 3'd0,
        LOAD1 = 3'd1,
        LOAD2 = 3'd2,
        CALC  = 3'd3,
        OUT   = 3'd4
    } state_t;

    // Behavioural reference for the CSA: zero-extended three-way sum.
    function automatic logic [OP_W+1:0] ref_sum(
        input logic [OP_W-1:0] a,
        input logic [OP_W-1:0] b,
        input logic [OP_W-1:0] c
    );
        ref_sum = {2'b00, a} + {2'b00, b} + {2'b00, c};
    endfunction

    state_t            state_q;
    logic [OP_W-1:0]   x_q;
    logic [OP_W-1:0]   y_q;
    logic [OP_W-1:0]   z_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [OP_W+1:0]   out_sum_q;
    logic [1:0]        out_nops_q;
    logic              out_last_q;
    logic [1:0]        nops_q;
    logic              last_q;
    logic [CNT_W-1:0]  grp_q;
    logic              err_q;

    logic              xfer_d;
    logic [OP_W+1:0]   csa_res_d;
    logic [OP_W+1:0]   ref_res_d;

    // Handshake qualifier and the two views of the sum compared in CALC.
    always_comb begin
        xfer_d    = bus.in_valid & in_ready_q;
        csa_res_d = {csa_cout, csa_s};
        ref_res_d = ref_sum(x_q, y_q, z_q);
    end

    // Group sequencing FSM with all datapath and output registers.
    // in_ready is registered so that it stays low while reset is held and
    // rises on the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD0;
            x_q         <= {OP_W{1'b0}};
            y_q         <= {OP_W{1'b0}};
            z_q         <= {OP_W{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= {(OP_W+2){1'b0}};
            out_nops_q  <= 2'd0;
            out_last_q  <= 1'b0;
            nops_q      <= 2'd0;
            last_q      <= 1'b0;
            grp_q       <= {CNT_W{1'b0}};
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                LOAD0: begin
                    if (xfer_d) begin
                        x_q <= bus.in_data;
                        y_q <= {OP_W{1'b0}};
                        z_q <= {OP_W{1'b0}};
                        if (bus.in_last) begin
                            nops_q     <= 2'd1;
                            last_q     <= 1'b1;
                            in_ready_q <= 1'b0;
                            state_q    <= CALC;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= LOAD1;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                LOAD1: begin
                    if (xfer_d) begin
                        y_q <= bus.in_data;
                        if (bus.in_last) begin
                            nops_q     <= 2'd2;
                            last_q     <= 1'b1;
                            in_ready_q <= 1'b0;
                            state_q    <= CALC;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= LOAD2;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                LOAD2: begin
                    if (xfer_d) begin
                        z_q        <= bus.in_data;
                        nops_q     <= 2'd3;
                        last_q     <= bus.in_last;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                CALC: begin
                    out_sum_q   <= csa_res_d;
                    out_nops_q  <= nops_q;
                    out_last_q  <= last_q;
                    if (csa_res_d != ref_res_d) begin
                        err_q <= 1'b1;
                    end else begin
                        err_q <= err_q;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        grp_q       <= grp_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        x_q         <= {OP_W{1'b0}};
                        y_q         <= {OP_W{1'b0}};
                        z_q         <= {OP_W{1'b0}};
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= LOAD0;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= LOAD0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_nops  = out_nops_q;
    assign bus.out_last  = out_last_q;
    assign csa_x         = x_q;
    assign csa_y         = y_q;
    assign csa_z         = z_q;
    assign grp_cnt       = grp_q;
    assign err           = err_q;

endmodule

// File: tb/tb_csa_operand_sequencer.sv
// Directed plus randomized bench for csa_operand_sequencer. A behavioural
// CSA (plain addition, with an optional injected fault) sits on the CSA
// ports; expected results come from summing the operands of each group.
module tb_csa_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] csa_x, csa_y, csa_z;
    logic [4:0] csa_s;
    logic       csa_cout;
    logic [7:0] grp_cnt;
    logic       err;
    logic       bad_csa = 1'b0;

    int tests = 0;
    int fails = 0;
    int exp_grp = 0;

    csa_operand_sequencer_if #(.OP_W(4)) bus ();

    csa_operand_sequencer #(.OP_W(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .csa_x    (csa_x),
        .csa_y    (csa_y),
        .csa_z    (csa_z),
        .csa_s    (csa_s),
        .csa_cout (csa_cout),
        .grp_cnt  (grp_cnt),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Behavioural CSA stage; the fault forces s=0 for inputs 1,1,1.
    always_comb begin
        logic [5:0] t;
        t = {2'b00, csa_x} + {2'b00, csa_y} + {2'b00, csa_z};
        if (bad_csa && csa_x == 4'd1 && csa_y == 4'd1 && csa_z == 4'd1) begin
            t[4:0] = 5'd0;
        end
        {csa_cout, csa_s} = t;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand and return just after the edge that accepts it.
    task automatic send_op(input logic [3:0] d, input logic l);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Wait for a result, compare it, optionally stall, then take it.
    task automatic recv(input string tag, input int esum, input int enops, input int elast,
                        input int stall, output int waited);
        int n = 0;
        bus.out_ready = (stall == 0);
        while (bus.out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        waited = n;
        check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, "_sum"},   {26'd0, bus.out_sum},   esum);
        check({tag, "_nops"},  {30'd0, bus.out_nops},  enops);
        check({tag, "_last"},  {31'd0, bus.out_last},  elast);
        for (int i = 0; i < stall; i++) tick();
        bus.out_ready = 1'b1;
        tick();
        exp_grp++;
        check({tag, "_drop"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_grp"},  {24'd0, grp_cnt},       exp_grp % 256);
    endtask

    initial begin
        int w;
        int sum;
        int len;
        int lst;
        int stl;
        logic [3:0] ops [3];
        logic [5:0] held;

        bus.in_valid  = 1'b0;
        bus.in_data   = 4'd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state.
        #12;
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_sum",   {26'd0, bus.out_sum},   32'd0);
        check("rst_out_nops",  {30'd0, bus.out_nops},  32'd0);
        check("rst_out_last",  {31'd0, bus.out_last},  32'd0);
        check("rst_csa_x",     {28'd0, csa_x},         32'd0);
        check("rst_grp",       {24'd0, grp_cnt},       32'd0);
        check("rst_err",       {31'd0, err},           32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3,5,7 back to back with latency check.
        send_op(4'd3, 1'b0);
        send_op(4'd5, 1'b0);
        send_op(4'd7, 1'b0);
        check("lat_calc_novalid", {31'd0, bus.out_valid}, 32'd0);
        recv("g357", 15, 3, 0, 0, w);
        check("lat_357", w, 32'd1);
        check("clr_csa_x", {28'd0, csa_x}, 32'd0);

        // Maximum sum.
        send_op(4'd15, 1'b0);
        send_op(4'd15, 1'b0);
        send_op(4'd15, 1'b0);
        recv("g15", 45, 3, 0, 0, w);
        check("g15_err", {31'd0, err}, 32'd0);

        // Single operand closed early.
        send_op(4'd9, 1'b1);
        check("g9_x", {28'd0, csa_x}, 32'd9);
        check("g9_y", {28'd0, csa_y}, 32'd0);
        check("g9_z", {28'd0, csa_z}, 32'd0);
        recv("g9", 9, 1, 1, 0, w);
        check("lat_9", w, 32'd1);

        // Two operands closed early.
        send_op(4'd4, 1'b0);
        send_op(4'd6, 1'b1);
        recv("g46", 10, 2, 1, 0, w);

        // in_last on the third operand.
        send_op(4'd2, 1'b0);
        send_op(4'd3, 1'b0);
        send_op(4'd4, 1'b1);
        recv("g234", 9, 3, 1, 0, w);

        // Backpressure: 10 stalled cycles with an operand offered meanwhile.
        bus.out_ready = 1'b0;
        send_op(4'd1, 1'b0);
        send_op(4'd2, 1'b0);
        send_op(4'd3, 1'b0);
        tick();
        held = bus.out_sum;
        check("bp_sum_first", {26'd0, held}, 32'd6);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd8;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid",    {31'd0, bus.out_valid}, 32'd1);
            check("bp_sum",      {26'd0, bus.out_sum},   32'd6);
            check("bp_in_ready", {31'd0, bus.in_ready},  32'd0);
            check("bp_grp",      {24'd0, grp_cnt},       exp_grp);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        exp_grp++;
        check("bp_rel_grp", {24'd0, grp_cnt}, exp_grp);
        tick();
        check("bp_rel_drop", {31'd0, bus.out_valid}, 32'd0);
        check("bp_rel_grp2", {24'd0, grp_cnt}, exp_grp);
        check("bp_no_consume_x", {28'd0, csa_x}, 32'd0);

        // Randomized groups against the summing reference.
        for (int g = 0; g < 25; g++) begin
            len = $urandom_range(1, 3);
            lst = (len < 3) ? 1 : int'($urandom_range(0, 1));
            stl = $urandom_range(0, 3);
            sum = 0;
            bus.out_ready = (stl == 0);
            for (int k = 0; k < len; k++) begin
                ops[k] = 4'($urandom_range(0, 15));
                sum += ops[k];
                send_op(ops[k], (k == len - 1) ? lst[0] : 1'b0);
            end
            recv("rnd", sum, len, lst, stl, w);
        end
        check("rnd_err", {31'd0, err}, 32'd0);

        // Faulty CSA sets a sticky error.
        bad_csa = 1'b1;
        send_op(4'd1, 1'b0);
        send_op(4'd1, 1'b0);
        send_op(4'd1, 1'b0);
        recv("bad", 0, 3, 0, 0, w);
        check("bad_err", {31'd0, err}, 32'd1);
        bad_csa = 1'b0;
        send_op(4'd2, 1'b0);
        send_op(4'd2, 1'b1);
        recv("good_after", 4, 2, 1, 0, w);
        check("sticky_err", {31'd0, err}, 32'd1);

        // Reset mid-group aborts it and clears err.
        send_op(4'd7, 1'b0);
        send_op(4'd7, 1'b0);
        rst_n = 1'b0;
        #2;
        check("abort_err",   {31'd0, err},           32'd0);
        check("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_ready", {31'd0, bus.in_ready},  32'd0);
        check("abort_grp",   {24'd0, grp_cnt},       32'd0);
        exp_grp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send_op(4'd2, 1'b0);
        send_op(4'd2, 1'b0);
        send_op(4'd2, 1'b0);
        recv("post_abort", 6, 3, 0, 0, w);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
